// File: rtl/bullet_hit_scanner.sv
// bullet_hit_scanner: once per frame, walks every slot of the bullet table,
// tests each live bullet against the player heart box, accumulates damage and
// heal, applies them to HP and returns a per-slot keep-mask to the table.
// Optional feature macro: BULLET_IFRAME_EN (invulnerability frames after damage).
module bullet_hit_scanner #(
    parameter int N_BULLETS = 3,
    parameter int IDX_W     = 3,
    parameter int PLAYER_W  = 8,
    parameter int PLAYER_H  = 8,
    parameter int HP_MAX    = 20,
    parameter int DMG_HIT   = 4,
    parameter int HEAL_HIT  = 2,
    parameter int IFRAMES   = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 is_run,
    input  logic                 frame_tick,
    input  logic [7:0]           player_x,
    input  logic [7:0]           player_y,
    input  logic                 player_moving,
    output logic [IDX_W-1:0]     bullet_index,
    input  logic [15:0]          bullet_position,
    input  logic [15:0]          bullet_size,
    input  logic [2:0]           bullet_color,
    input  logic                 bullet_render,
    output logic [N_BULLETS-1:0] index_collide,
    output logic                 collide_valid,
    output logic [7:0]           hp,
    output logic                 dead,
    output logic                 damage_pulse,
    output logic                 scan_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_SAMPLE = 3'd2,
        S_EVAL   = 3'd3,
        S_APPLY  = 3'd4
    } state_t;

    localparam logic [7:0]           HP_MAX_C = 8'(HP_MAX);
    localparam logic [7:0]           DMG_C    = 8'(DMG_HIT);
    localparam logic [7:0]           HEAL_C   = 8'(HEAL_HIT);
    localparam logic [8:0]           PW_C     = 9'(PLAYER_W);
    localparam logic [8:0]           PH_C     = 9'(PLAYER_H);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_BULLETS - 1);
    localparam logic [N_BULLETS-1:0] ALL_ONES = {N_BULLETS{1'b1}};
    localparam logic [N_BULLETS-1:0] ALL_ZERO = {N_BULLETS{1'b0}};

    // 8-bit add that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_BULLETS-1:0] hit_mask_q, hit_mask_d;
    logic [7:0]           dmg_q, dmg_d;
    logic [7:0]           heal_q, heal_d;
    logic [15:0]          pos_q, pos_d;
    logic [15:0]          size_q, size_d;
    logic [2:0]           color_q, color_d;
    logic                 render_q, render_d;
    logic [N_BULLETS-1:0] collide_q, collide_d;
    logic                 cvalid_q, cvalid_d;
    logic [7:0]           hp_q, hp_d;
    logic                 dead_q, dead_d;
    logic                 dpulse_q, dpulse_d;
    logic                 busy_q, busy_d;

    logic                 overlap_s;
    logic                 hit_s;
    logic [7:0]           add_dmg_s;
    logic [7:0]           add_heal_s;
    logic [N_BULLETS-1:0] slot_bit_s;
    logic [N_BULLETS-1:0] mask_next_s;
    logic [7:0]           dmg_next_s;
    logic [7:0]           heal_next_s;
    logic [7:0]           dmg_eff_s;
    logic [7:0]           hp_sub_s;
    logic [7:0]           heal_eff_s;
    logic [8:0]           hp_sum_s;
    logic [7:0]           hp_new_s;

    // Box overlap of the sampled bullet against the heart, 9-bit so edges never wrap
    always_comb begin
        logic [8:0] bx, by, bw, bh, px, py;
        bx = {1'b0, pos_q[7:0]};
        by = {1'b0, pos_q[15:8]};
        bw = {1'b0, size_q[7:0]};
        bh = {1'b0, size_q[15:8]};
        px = {1'b0, player_x};
        py = {1'b0, player_y};
        overlap_s = (bx < px + PW_C) && (px < bx + bw) &&
                    (by < py + PH_C) && (py < by + bh);
    end

    // Per-slot effect by colour and the updated accumulators
    always_comb begin
        hit_s      = 1'b0;
        add_dmg_s  = 8'd0;
        add_heal_s = 8'd0;
        if (render_q && overlap_s) begin
            case (color_q)
                3'd0: begin
                    hit_s     = 1'b1;
                    add_dmg_s = DMG_C;
                end
                3'd1: begin
                    hit_s      = 1'b1;
                    add_heal_s = HEAL_C;
                end
                3'd2: begin
                    hit_s     = 1'b1;
                    add_dmg_s = player_moving ? DMG_C : 8'd0;
                end
                default: begin
                    hit_s = 1'b0;
                end
            endcase
        end else begin
            hit_s = 1'b0;
        end
        slot_bit_s  = N_BULLETS'(1'b1) << idx_q;
        mask_next_s = hit_s ? (hit_mask_q | slot_bit_s) : hit_mask_q;
        dmg_next_s  = sat_add8(dmg_q, add_dmg_s);
        heal_next_s = sat_add8(heal_q, add_heal_s);
    end

`ifdef BULLET_IFRAME_EN
    logic [7:0] iframe_q, iframe_d;

    // Damage is suppressed while invulnerability frames remain
    always_comb begin
        dmg_eff_s = (iframe_q != 8'd0) ? 8'd0 : dmg_next_s;
    end

    // Invulnerability counter: reload on applied damage, count down on frame ticks
    always_comb begin
        iframe_d = iframe_q;
        if (!is_run) begin
            iframe_d = 8'd0;
        end else if (state_q == S_EVAL && idx_q == LAST_IDX && dmg_eff_s != 8'd0) begin
            iframe_d = 8'(IFRAMES);
        end else if (frame_tick && iframe_q != 8'd0) begin
            iframe_d = iframe_q - 8'd1;
        end else begin
            iframe_d = iframe_q;
        end
    end

    // Invulnerability counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iframe_q <= 8'd0;
        end else begin
            iframe_q <= iframe_d;
        end
    end
`else
    // Without invulnerability every accumulated damage point applies
    always_comb begin
        dmg_eff_s = dmg_next_s;
    end
`endif

    // New HP: damage first (floored at 0), then heal unless dead, capped at HP_MAX
    always_comb begin
        hp_sub_s   = (hp_q > dmg_eff_s) ? (hp_q - dmg_eff_s) : 8'd0;
        heal_eff_s = dead_q ? 8'd0 : heal_next_s;
        hp_sum_s   = {1'b0, hp_sub_s} + {1'b0, heal_eff_s};
        hp_new_s   = (hp_sum_s > {1'b0, HP_MAX_C}) ? HP_MAX_C : hp_sum_s[7:0];
    end

    // Scan sequencer next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hit_mask_d = hit_mask_q;
        dmg_d      = dmg_q;
        heal_d     = heal_q;
        pos_d      = pos_q;
        size_d     = size_q;
        color_d    = color_q;
        render_d   = render_q;
        collide_d  = collide_q;
        cvalid_d   = cvalid_q;
        hp_d       = hp_q;
        dead_d     = dead_q;
        dpulse_d   = dpulse_q;
        busy_d     = busy_q;
        if (!is_run) begin
            state_d   = S_IDLE;
            idx_d     = {IDX_W{1'b0}};
            collide_d = ALL_ONES;
            cvalid_d  = 1'b0;
            hp_d      = HP_MAX_C;
            dead_d    = 1'b0;
            dpulse_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    collide_d = ALL_ONES;
                    cvalid_d  = 1'b0;
                    dpulse_d  = 1'b0;
                    if (frame_tick) begin
                        hit_mask_d = ALL_ZERO;
                        dmg_d      = 8'd0;
                        heal_d     = 8'd0;
                        idx_d      = {IDX_W{1'b0}};
                        busy_d     = 1'b1;
                        state_d    = S_ADDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ADDR: begin
                    state_d = S_SAMPLE;
                end
                S_SAMPLE: begin
                    pos_d    = bullet_position;
                    size_d   = bullet_size;
                    color_d  = bullet_color;
                    render_d = bullet_render;
                    state_d  = S_EVAL;
                end
                S_EVAL: begin
                    hit_mask_d = mask_next_s;
                    dmg_d      = dmg_next_s;
                    heal_d     = heal_next_s;
                    if (idx_q == LAST_IDX) begin
                        collide_d = ~mask_next_s;
                        cvalid_d  = 1'b1;
                        hp_d      = hp_new_s;
                        dead_d    = dead_q | (hp_new_s == 8'd0);
                        dpulse_d  = (dmg_eff_s != 8'd0) && !dead_q;
                        state_d   = S_APPLY;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_ADDR;
                    end
                end
                S_APPLY: begin
                    collide_d = ALL_ONES;
                    cvalid_d  = 1'b0;
                    dpulse_d  = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
                default: begin
                    collide_d = ALL_ONES;
                    cvalid_d  = 1'b0;
                    dpulse_d  = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            endcase
        end
    end

    // Sequencer state, sample registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            hit_mask_q <= ALL_ZERO;
            dmg_q      <= 8'd0;
            heal_q     <= 8'd0;
            pos_q      <= 16'd0;
            size_q     <= 16'd0;
            color_q    <= 3'd0;
            render_q   <= 1'b0;
            collide_q  <= ALL_ONES;
            cvalid_q   <= 1'b0;
            hp_q       <= HP_MAX_C;
            dead_q     <= 1'b0;
            dpulse_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hit_mask_q <= hit_mask_d;
            dmg_q      <= dmg_d;
            heal_q     <= heal_d;
            pos_q      <= pos_d;
            size_q     <= size_d;
            color_q    <= color_d;
            render_q   <= render_d;
            collide_q  <= collide_d;
            cvalid_q   <= cvalid_d;
            hp_q       <= hp_d;
            dead_q     <= dead_d;
            dpulse_q   <= dpulse_d;
            busy_q     <= busy_d;
        end
    end

    assign bullet_index  = idx_q;
    assign index_collide = collide_q;
    assign collide_valid = cvalid_q;
    assign hp            = hp_q;
    assign dead          = dead_q;
    assign damage_pulse  = dpulse_q;
    assign scan_busy     = busy_q;

endmodule
